// File: rtl/corevx_mem_pkg.sv
// Shared memory-stage definitions: load/store type codes, store completion
// status encodings and the store-unit state type.
package corevx_mem_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        LOAD_BYTE   = 3'b000,
        LOAD_HALF   = 3'b001,
        LOAD_WORD   = 3'b010,
        LOAD_BYTE_U = 3'b100,
        LOAD_HALF_U = 3'b101
    } load_type_e;

    localparam logic [2:0] STORE_BYTE = 3'b000;
    localparam logic [2:0] STORE_HALF = 3'b001;
    localparam logic [2:0] STORE_WORD = 3'b010;

    typedef enum logic [1:0] {
        ST_OK           = 2'd0,
        ST_MISALIGNED   = 2'd1,
        ST_UNKNOWN_TYPE = 2'd2,
        ST_BUS_ERROR    = 2'd3
    } done_status_e;

    typedef enum logic [1:0] {
        SU_IDLE,
        SU_ISSUE,
        SU_WAIT_RESP,
        SU_RESPOND
    } su_state_e;

    // Expand a 4-bit byte strobe into a 32-bit lane mask.
    function automatic logic [XLEN-1:0] strb_to_mask(input logic [3:0] strb);
        logic [XLEN-1:0] mask;
        for (int b = 0; b < 4; b++) begin
            mask[b*8 +: 8] = {8{strb[b]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/corevx_storegen.sv
// Combinational store lane generator: places store data on the byte lanes
// selected by the low address bits and flags misaligned or unknown types.
module corevx_storegen
    import corevx_mem_pkg::*;
(
    input  logic [1:0]      off_i,
    input  logic [2:0]      type_i,
    input  logic [XLEN-1:0] data_i,
    output logic [XLEN-1:0] wdata_o,
    output logic [3:0]      wstrb_o,
    output logic            misaligned_o,
    output logic            unknown_type_o
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        wstrb_o        = 4'b0000;
        misaligned_o   = 1'b0;
        unknown_type_o = 1'b0;
        case (type_i)
            STORE_BYTE: begin
                wstrb_o = 4'b0001 << off_i;
            end
            STORE_HALF: begin
                wstrb_o      = 4'b0011 << off_i;
                misaligned_o = off_i[0];
            end
            STORE_WORD: begin
                wstrb_o      = 4'b1111;
                misaligned_o = (off_i != 2'b00);
            end
            default: begin
                unknown_type_o = 1'b1;
            end
        endcase
    end

    assign shifted = data_i << {off_i, 3'b000};
    assign wdata_o = shifted & strb_to_mask(wstrb_o);

endmodule

// File: rtl/corevx_storeunit.sv
// Store unit: accepts one store at a time, issues a word-aligned strobed bus
// write and returns a single completion pulse with status and address.
module corevx_storeunit
    import corevx_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [2:0]  req_type,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_resp_valid,
    input  logic        mem_resp_error,
    output logic        done_valid,
    output logic [1:0]  done_status,
    output logic [31:0] done_addr
);

    su_state_e    state_q,  state_d;
    logic [31:0]  addr_q,   addr_d;
    logic [31:0]  wdata_q,  wdata_d;
    logic [3:0]   wstrb_q,  wstrb_d;
    done_status_e status_q, status_d;

    logic [31:0]  gen_wdata;
    logic [3:0]   gen_wstrb;
    logic         gen_misaligned;
    logic         gen_unknown;

    corevx_storegen u_storegen (
        .off_i          (req_addr[1:0]),
        .type_i         (req_type),
        .data_i         (req_data),
        .wdata_o        (gen_wdata),
        .wstrb_o        (gen_wstrb),
        .misaligned_o   (gen_misaligned),
        .unknown_type_o (gen_unknown)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        status_d = status_q;
        case (state_q)
            SU_IDLE: begin
                if (req_valid) begin
                    addr_d = req_addr;
                    // Faulting stores never reach the bus, so keep its lanes quiet.
                    if (gen_unknown) begin
                        wdata_d  = '0;
                        wstrb_d  = '0;
                        status_d = ST_UNKNOWN_TYPE;
                        state_d  = SU_RESPOND;
                    end else if (gen_misaligned) begin
                        wdata_d  = '0;
                        wstrb_d  = '0;
                        status_d = ST_MISALIGNED;
                        state_d  = SU_RESPOND;
                    end else begin
                        wdata_d  = gen_wdata;
                        wstrb_d  = gen_wstrb;
                        status_d = ST_OK;
                        state_d  = SU_ISSUE;
                    end
                end
            end
            SU_ISSUE: begin
                if (mem_ready) begin
                    state_d = SU_WAIT_RESP;
                end
            end
            SU_WAIT_RESP: begin
                if (mem_resp_valid) begin
                    status_d = mem_resp_error ? ST_BUS_ERROR : ST_OK;
                    state_d  = SU_RESPOND;
                end
            end
            SU_RESPOND: begin
                state_d = SU_IDLE;
            end
            default: begin
                state_d = SU_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= SU_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            status_q <= ST_OK;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            status_q <= status_d;
        end
    end

    assign req_ready   = (state_q == SU_IDLE);
    assign mem_valid   = (state_q == SU_ISSUE);
    assign done_valid  = (state_q == SU_RESPOND);
    assign mem_addr    = {addr_q[31:2], 2'b00};
    assign mem_wdata   = wdata_q;
    assign mem_wstrb   = wstrb_q;
    assign done_status = status_q;
    assign done_addr   = addr_q;

endmodule
